// File: rtl/icg_ctrl_pkg.sv
// Shared state encoding, default timing and counter sizing for the ICG enable controller.
package icg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_GATED  = 2'd1,
    ST_WAKING = 2'd2
  } icg_state_t;

  localparam int unsigned DEF_IDLE_CYCLES = 16;
  localparam int unsigned DEF_WAKE_CYCLES = 2;
  localparam int unsigned DEF_CNT_W       = 16;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/icg_sat_counter.sv
// Purpose: event counter that sticks at all-ones instead of wrapping.
// Latency: count updates on the core_clk edge that samples inc.
// Backpressure: none; inc is accepted every cycle, ignored once saturated.
module icg_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         core_clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge core_clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/icg_enable_ctrl.sv
// Purpose: drives E/TE of the icgtp cell; gates after an idle window or sleep request, reopens on wake.
// Latency: gating takes effect on the deciding edge; WAKE to READY is WAKE_CYCLES+1 edges.
// Backpressure: none; WAKE/SLEEP_REQ are levels sampled every edge, ignored in states that cannot act on them.
module icg_enable_ctrl
  import icg_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ACTIVE,
  input  logic             WAKE,
  input  logic             SLEEP_REQ,
  input  logic             FORCE_ON,
  input  logic             SE,
  output logic             E,
  output logic             TE,
  output logic             READY,
  output logic             GATED,
  output logic             SLEEP_ACK,
  output logic [CNT_W-1:0] GATE_CNT
);

  localparam int unsigned IDLE_W = cnt_width(IDLE_CYCLES - 1);
  localparam int unsigned WAKE_W = cnt_width(WAKE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  icg_state_t        state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAKE_W-1:0] wake_cnt;

  logic keep_on;
  logic sleep_now;
  logic idle_expired;
  logic gate_evt;

  // FORCE_ON, ACTIVE and WAKE all outrank SLEEP_REQ, which outranks the idle timeout.
  assign keep_on      = FORCE_ON | ACTIVE | WAKE;
  assign sleep_now    = (state == ST_RUN) && !keep_on && SLEEP_REQ;
  assign idle_expired = (state == ST_RUN) && !keep_on && (idle_cnt == IDLE_LAST);
  assign gate_evt     = sleep_now | idle_expired;

  // Scan path opens the ICG on its own; the FSM never sees SE.
  assign TE = SE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_RUN;
      E         <= 1'b1;
      READY     <= 1'b1;
      GATED     <= 1'b0;
      SLEEP_ACK <= 1'b0;
      idle_cnt  <= '0;
      wake_cnt  <= '0;
    end else begin
      SLEEP_ACK <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (keep_on) begin
            idle_cnt <= '0;
          end else if (gate_evt) begin
            state     <= ST_GATED;
            E         <= 1'b0;
            READY     <= 1'b0;
            GATED     <= 1'b1;
            SLEEP_ACK <= sleep_now;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_GATED: begin
          if (WAKE || FORCE_ON) begin
            state    <= ST_WAKING;
            E        <= 1'b1;
            READY    <= 1'b0;
            GATED    <= 1'b0;
            wake_cnt <= '0;
          end
        end
        ST_WAKING: begin
          // E stays high through the settle window so the gated clock is clean before READY.
          if (wake_cnt == WAKE_LAST) begin
            state    <= ST_RUN;
            READY    <= 1'b1;
            idle_cnt <= '0;
            wake_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_RUN;
          E        <= 1'b1;
          READY    <= 1'b1;
          GATED    <= 1'b0;
          idle_cnt <= '0;
          wake_cnt <= '0;
        end
      endcase
    end
  end

  icg_sat_counter #(
    .W (CNT_W)
  ) u_gate_cnt (
    .core_clk (CLK),
    .clr      (RST),
    .inc      (gate_evt),
    .cnt      (GATE_CNT)
  );

endmodule
